pa_dst_writer: RTL and testbench

- Result write-back engine at the consumer end of the PE-array result handshake.
- Accepts one 32-bit result per transfer from the PE-array controller (dst_wr_rdy / dst_wr_acq), 16 results per tile, into a small FIFO.
- Drains the FIFO to the memory write port with a valid/ready handshake and signals tile and job completion.

---
 rtl/pa_dst_pkg.sv | 43 ++++
 rtl/pa_dst_fifo.sv | 70 +++++++
 rtl/pa_dst_writer.sv | 174 +++++++++++++++++
 tb/tb_pa_dst_writer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_dst_pkg.sv
// -----------------------------------------------------------------------------
// pa_dst_pkg
// Shared types and helpers for the PE-array result write-back engine.
//   state_t       : writer FSM encoding (IDLE / RUN / DRAIN)
//   TILE_LEN_DEF  : default results per tile (4-bit producer result index)
//   INT8_MIN/MAX  : saturation bounds for the optional requantiser
//   requant()     : arithmetic shift with round-half-up, clamped to int8 and
//                   sign-extended back to 32 bits
// Optional feature macro referenced by users of this package: PA_DST_REQUANT_EN
// -----------------------------------------------------------------------------
package pa_dst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    localparam int TILE_LEN_DEF = 16;

    localparam logic signed [31:0] INT8_MIN = -32'sd128;
    localparam logic signed [31:0] INT8_MAX = 32'sd127;

    // Round half up: add half an LSB of the shifted result before the
    // arithmetic shift. One guard bit keeps the addition from overflowing.
    function automatic logic signed [31:0] requant(input logic signed [31:0] x,
                                                   input logic [4:0]         sh);
        logic signed [32:0] ext;
        logic signed [32:0] half;
        logic signed [32:0] q;
        ext  = {x[31], x};
        half = (sh == 5'd0) ? 33'sd0 : (33'sd1 <<< (sh - 5'd1));
        q    = (ext + half) >>> sh;
        if (q > 33'sd127) begin
            return INT8_MAX;
        end
        if (q < -33'sd128) begin
            return INT8_MIN;
        end
        return q[31:0];
    endfunction

endpackage

// File: rtl/pa_dst_fifo.sv
// -----------------------------------------------------------------------------
// pa_dst_fifo
// Synchronous FIFO holding {address, data} write requests.
// Storage is not reset; only pointers and occupancy are.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, pop  : enqueue din / dequeue head (ignored when full / empty)
//   din, dout  : entry in, head entry out (valid when !empty)
//   full, empty, count : occupancy status (count is one bit wider than ptrs)
// -----------------------------------------------------------------------------
module pa_dst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/pa_dst_writer.sv
// -----------------------------------------------------------------------------
// pa_dst_writer
// Result write-back engine: accepts TILE_LEN results per tile from the PE-array
// controller, buffers {addr, data} in a FIFO and drains it to memory.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start, num_tiles,
//   base_addr               : job start (IDLE only), tile count (0 -> 1), base
//   dst_wr_rdy / dst_wr_acq : producer handshake, dst_data / dst_offset payload
//   mem_wr_valid / _ready   : memory write handshake, mem_wr_addr / mem_wr_data
//   tile_done, job_done     : one-cycle completion pulses
//   busy                    : high outside IDLE
// Optional feature: define PA_DST_REQUANT_EN to add dst_shift (int8 requant,
// byte addressing) and mem_wr_strb (one-hot byte strobe).
// -----------------------------------------------------------------------------
module pa_dst_writer
    import pa_dst_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TILE_LEN   = TILE_LEN_DEF,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       num_tiles,
    input  logic [ADDR_W-1:0] base_addr,
`ifdef PA_DST_REQUANT_EN
    input  logic [4:0]        dst_shift,
`endif
    input  logic              dst_wr_rdy,
    output logic              dst_wr_acq,
    input  logic [31:0]       dst_data,
    input  logic [31:0]       dst_offset,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
`ifdef PA_DST_REQUANT_EN
    output logic [3:0]        mem_wr_strb,
`endif
    output logic              tile_done,
    output logic              job_done,
    output logic              busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = $clog2(TILE_LEN);
    localparam int FW = ADDR_W + 32;
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [EW-1:0] ELEM_LAST = EW'(TILE_LEN - 1);
    localparam logic [EW-1:0] ELEM_ONE  = EW'(1);

    state_t            state;
    logic [15:0]       num_tiles_q;
    logic [15:0]       tile_cnt;
    logic [EW-1:0]     elem_cnt;
    logic [ADDR_W-1:0] base_q;
    logic              in_xfer;
    logic              mem_xfer;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [FW-1:0]     fifo_din;
    logic [FW-1:0]     fifo_dout;
    logic [ADDR_W-1:0] push_addr;
    logic [31:0]       push_data;

    // Acceptance looks only at the registered occupancy, so a pop in the
    // same cycle never frees a slot for the current push.
    assign dst_wr_acq = (state == RUN) && (fifo_count < CNT_FULL);
    assign in_xfer    = dst_wr_rdy && dst_wr_acq;
    assign mem_xfer   = mem_wr_valid && mem_wr_ready;
    assign busy       = (state != IDLE);

`ifdef PA_DST_REQUANT_EN
    logic [4:0] shift_q;

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            shift_q <= dst_shift;
        end
    end

    assign push_addr = base_q + ADDR_W'(dst_offset);
    assign push_data = requant(dst_data, shift_q);
`else
    logic [33:0] offset_bytes;

    assign offset_bytes = {dst_offset, 2'b00};
    assign push_addr    = base_q + ADDR_W'(offset_bytes);
    assign push_data    = dst_data;
`endif

    assign fifo_din = {push_addr, push_data};

    pa_dst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_xfer && !fifo_full),
        .pop   (mem_xfer),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // FIFO storage is not reset, so the head is masked to read 0 when empty.
    assign mem_wr_valid = !fifo_empty;
    assign mem_wr_addr  = fifo_empty ? '0 : fifo_dout[FW-1:32];
    assign mem_wr_data  = fifo_empty ? '0 : fifo_dout[31:0];
`ifdef PA_DST_REQUANT_EN
    assign mem_wr_strb  = fifo_empty ? 4'b0000 : (4'b0001 << mem_wr_addr[1:0]);
`endif

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            base_q <= base_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            num_tiles_q <= '0;
            tile_cnt    <= '0;
            elem_cnt    <= '0;
            tile_done   <= 1'b0;
            job_done    <= 1'b0;
        end else begin
            tile_done <= 1'b0;
            job_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_tiles_q <= (num_tiles == 16'd0) ? 16'd1 : num_tiles;
                        tile_cnt    <= '0;
                        elem_cnt    <= '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (in_xfer) begin
                        if (elem_cnt == ELEM_LAST) begin
                            elem_cnt <= '0;
                            state    <= DRAIN;
                        end else begin
                            elem_cnt <= elem_cnt + ELEM_ONE;
                        end
                    end
                end
                DRAIN: begin
                    // Empty FIFO means no write is pending on the memory port.
                    if (fifo_empty) begin
                        tile_done <= 1'b1;
                        tile_cnt  <= tile_cnt + 16'd1;
                        if (tile_cnt + 16'd1 == num_tiles_q) begin
                            job_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pa_dst_writer.sv
module tb_pa_dst_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_tiles;
    logic [31:0] base_addr;
    logic        dst_wr_rdy;
    logic        dst_wr_acq;
    logic [31:0] dst_data;
    logic [31:0] dst_offset;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        tile_done;
    logic        job_done;
    logic        busy;
`ifdef PA_DST_REQUANT_EN
    logic [4:0]  dst_shift;
    logic [3:0]  mem_wr_strb;
    logic [4:0]  shift_val;
    logic [3:0]  obs_strb[$];
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] gen_off[$];
    logic [31:0] gen_dat[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    always #5 clk = ~clk;

    pa_dst_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_tiles    (num_tiles),
        .base_addr    (base_addr),
`ifdef PA_DST_REQUANT_EN
        .dst_shift    (dst_shift),
`endif
        .dst_wr_rdy   (dst_wr_rdy),
        .dst_wr_acq   (dst_wr_acq),
        .dst_data     (dst_data),
        .dst_offset   (dst_offset),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
`ifdef PA_DST_REQUANT_EN
        .mem_wr_strb  (mem_wr_strb),
`endif
        .tile_done    (tile_done),
        .job_done     (job_done),
        .busy         (busy)
    );

    // Reference model: expected memory request for a result.
    function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic [31:0] off);
`ifdef PA_DST_REQUANT_EN
        return base + off;
`else
        return base + off * 32'd4;
`endif
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] d);
`ifdef PA_DST_REQUANT_EN
        real r;
        int  q;
        r = $floor($itor($signed(d)) / (2.0 ** shift_val) + 0.5);
        q = int'(r);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
`else
        return d;
`endif
    endfunction

    task automatic fill_random(input int n);
        gen_off.delete();
        gen_dat.delete();
        for (int i = 0; i < n; i++) begin
            gen_off.push_back($urandom);
            gen_dat.push_back($urandom);
        end
`ifdef PA_DST_REQUANT_EN
        shift_val = 5'($urandom_range(0, 31));
`endif
    endtask

    // Runs one job; scoreboard compares every memory write against the model.
    task automatic run_job(input logic [15:0] nt, input logic [31:0] base, input bit rdy_rand,
                           input int ready_mode, input int stall_len,
                           output int acc_at_stall, output int pp3);
        int eff, total, p, pops, tiles, jobs, in_tile, last_pop, cyc, phase;
        logic acq_e, valid_e, prev_stall, do_push, do_pop;
        logic [31:0] prev_addr, prev_data;
        eff = (nt == 16'd0) ? 1 : int'(nt);
        total = eff * 16;
        obs_addr.delete();
        obs_data.delete();
`ifdef PA_DST_REQUANT_EN
        obs_strb.delete();
`endif
        acc_at_stall = 0;
        pp3 = 0;
        @(negedge clk);
        start = 1'b1; num_tiles = nt; base_addr = base; dst_wr_rdy = 1'b0; mem_wr_ready = 1'b0;
`ifdef PA_DST_REQUANT_EN
        dst_shift = shift_val;
`endif
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_before_start: got %b expected 0", busy);
        end
        phase = 1; p = 0; pops = 0; tiles = 0; jobs = 0; in_tile = 0; last_pop = -10; cyc = 0;
        prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
        while (phase != 0 && cyc < 3000) begin
            @(negedge clk);
            // Latched job parameters must not follow these later changes.
            start = (phase == 1) && ($urandom_range(0, 15) == 0);
            num_tiles = 16'($urandom);
            base_addr = $urandom;
`ifdef PA_DST_REQUANT_EN
            dst_shift = 5'($urandom);
`endif
            dst_wr_rdy = (p < total) && (!rdy_rand || $urandom_range(0, 3) != 0);
            if (p < total) begin
                dst_offset = gen_off[p];
                dst_data = gen_dat[p];
            end
            case (ready_mode)
                0: mem_wr_ready = 1'b1;
                1: mem_wr_ready = ($urandom_range(0, 2) != 0);
                default: mem_wr_ready = (cyc >= stall_len);
            endcase
            #1;
            checks++;
            if (tile_done) begin
                if (phase != 2 || pops != p || cyc != last_pop + 2) begin
                    errors++;
                    $display("FAIL tile_done_timing: got cycle %0d expected %0d (retired %0d of %0d)", cyc, last_pop + 2, pops, p);
                end
                tiles++;
                phase = (tiles == eff) ? 0 : 1;
            end else if (phase == 2 && pops == p && cyc == last_pop + 2) begin
                errors++; $display("FAIL tile_done_missing: got 0 expected 1 at cycle %0d", cyc);
            end
            checks++;
            if (job_done !== (tile_done && tiles == eff)) begin
                errors++; $display("FAIL job_done: got %b expected %b", job_done, tile_done && tiles == eff);
            end
            if (job_done) jobs++;
            checks++;
            if (busy !== (phase != 0)) begin
                errors++; $display("FAIL busy: got %b expected %b", busy, phase != 0);
            end
            acq_e = (phase == 1) && ((p - pops) < 4);
            checks++;
            if (dst_wr_acq !== acq_e) begin
                errors++; $display("FAIL dst_wr_acq: got %b expected %b (cycle %0d)", dst_wr_acq, acq_e, cyc);
            end
            valid_e = (p - pops) > 0;
            checks++;
            if (mem_wr_valid !== valid_e) begin
                errors++; $display("FAIL mem_wr_valid: got %b expected %b (cycle %0d)", mem_wr_valid, valid_e, cyc);
            end
            if (valid_e && pops < total) begin
                checks++;
                if (mem_wr_addr !== exp_addr(base, gen_off[pops]) || mem_wr_data !== exp_data(gen_dat[pops])) begin
                    errors++;
                    $display("FAIL write_%0d: got %h/%h expected %h/%h", pops, mem_wr_addr, mem_wr_data,
                             exp_addr(base, gen_off[pops]), exp_data(gen_dat[pops]));
                end
`ifdef PA_DST_REQUANT_EN
                checks++;
                if (mem_wr_strb !== (4'b0001 << exp_addr(base, gen_off[pops]) % 4)) begin
                    errors++; $display("FAIL strb_%0d: got %b", pops, mem_wr_strb);
                end
`endif
            end
            if (prev_stall) begin
                checks++;
                if (mem_wr_addr !== prev_addr || mem_wr_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable: got %h/%h expected %h/%h", mem_wr_addr, mem_wr_data, prev_addr, prev_data);
                end
            end
            do_pop = mem_wr_valid && mem_wr_ready;
            do_push = dst_wr_rdy && dst_wr_acq;
            if (do_push && do_pop && (p - pops) == 3) pp3++;
            if (do_pop) begin
                obs_addr.push_back(mem_wr_addr);
                obs_data.push_back(mem_wr_data);
`ifdef PA_DST_REQUANT_EN
                obs_strb.push_back(mem_wr_strb);
`endif
                pops++;
                last_pop = cyc;
            end
            if (do_push) begin
                p++;
                in_tile++;
                if (in_tile == 16) begin
                    in_tile = 0;
                    phase = 2;
                end
            end
            if (cyc == stall_len - 1) acc_at_stall = p;
            prev_stall = mem_wr_valid && !mem_wr_ready;
            prev_addr = mem_wr_addr;
            prev_data = mem_wr_data;
            cyc++;
        end
        start = 1'b0;
        dst_wr_rdy = 1'b0;
        checks++;
        if (phase != 0) begin
            errors++; $display("FAIL job_timeout: got phase %0d expected 0 after %0d cycles", phase, cyc);
        end
        checks++;
        if (jobs != 1 || tiles != eff || pops != total) begin
            errors++;
            $display("FAIL job_summary: got jobs=%0d tiles=%0d writes=%0d expected 1/%0d/%0d", jobs, tiles, pops, eff, total);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dst_wr_acq !== 1'b0 || busy !== 1'b0 || mem_wr_valid !== 1'b0) begin
            errors++; $display("FAIL idle_after_job: got acq=%b busy=%b valid=%b expected 0", dst_wr_acq, busy, mem_wr_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_tiles = '0; base_addr = '0; dst_wr_rdy = 1'b1;
        dst_data = 32'hDEAD_BEEF; dst_offset = 32'h3; mem_wr_ready = 1'b1;
`ifdef PA_DST_REQUANT_EN
        dst_shift = '0; shift_val = 5'd4;
`endif
        #12;
        checks++;
        if ({dst_wr_acq, mem_wr_valid, tile_done, job_done, busy} !== 5'b0 || mem_wr_addr !== '0 || mem_wr_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got acq=%b valid=%b td=%b jd=%b busy=%b addr=%h data=%h expected all 0",
                     dst_wr_acq, mem_wr_valid, tile_done, job_done, busy, mem_wr_addr, mem_wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dst_wr_rdy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (dst_wr_acq !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_ignores_rdy: got acq=%b busy=%b expected 0", dst_wr_acq, busy);
        end
    endtask

    task automatic test_single_tile();
        int a, b;
        gen_off.delete();
        gen_dat.delete();
        for (int i = 0; i < 16; i++) begin
            gen_off.push_back(i);
            gen_dat.push_back(i * 3);
        end
`ifdef PA_DST_REQUANT_EN
        shift_val = 5'd0;
`endif
        run_job(16'd1, 32'h1000, 1'b0, 0, 0, a, b);
        checks++;
        if (obs_addr.size() != 16) begin
            errors++; $display("FAIL single_tile_count: got %0d expected 16", obs_addr.size());
        end
`ifndef PA_DST_REQUANT_EN
        for (int i = 0; i < 16 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== 32'h1000 + 32'(i * 4) || obs_data[i] !== 32'(i * 3)) begin
                errors++;
                $display("FAIL single_tile_%0d: got %h/%h expected %h/%h", i, obs_addr[i], obs_data[i],
                         32'h1000 + 32'(i * 4), 32'(i * 3));
            end
        end
`endif
    endtask

    task automatic test_mem_stall();
        int acc, pp;
        fill_random(16);
        run_job(16'd1, $urandom, 1'b0, 2, 20, acc, pp);
        checks++;
        if (acc != 4) begin
            errors++; $display("FAIL stall_accepts: got %0d expected 4", acc);
        end
    endtask

    task automatic test_push_pop();
        int acc, pp;
        fill_random(16);
        run_job(16'd1, $urandom, 1'b0, 2, 3, acc, pp);
        checks++;
        if (pp < 1) begin
            errors++; $display("FAIL push_pop_at_3: got %0d simultaneous transfers expected at least 1", pp);
        end
    endtask

    task automatic test_multi_tile();
        int acc, pp;
        fill_random(48);
        run_job(16'd3, $urandom, 1'b1, 1, 0, acc, pp);
        fill_random(16);
        run_job(16'd0, $urandom, 1'b1, 1, 0, acc, pp);
    endtask

    task automatic test_reset_mid();
        int acc, a, b;
        fill_random(16);
        @(negedge clk);
        start = 1'b1; num_tiles = 16'd1; base_addr = $urandom;
        @(negedge clk);
        start = 1'b0; dst_wr_rdy = 1'b1; mem_wr_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 40 && acc < 7; i++) begin
            dst_offset = gen_off[acc];
            dst_data = gen_dat[acc];
            #1;
            if (dst_wr_acq) acc++;
            @(negedge clk);
        end
        checks++;
        if (acc != 7) begin
            errors++; $display("FAIL reset_mid_accepts: got %0d expected 7", acc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dst_wr_acq, mem_wr_valid, tile_done, job_done, busy} !== 5'b0 || mem_wr_addr !== '0 || mem_wr_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got acq=%b valid=%b td=%b jd=%b busy=%b addr=%h data=%h expected all 0",
                     dst_wr_acq, mem_wr_valid, tile_done, job_done, busy, mem_wr_addr, mem_wr_data);
        end
        dst_wr_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            checks++;
            if (tile_done !== 1'b0 || job_done !== 1'b0 || mem_wr_valid !== 1'b0) begin
                errors++; $display("FAIL reset_mid_quiet: got td=%b jd=%b valid=%b expected 0", tile_done, job_done, mem_wr_valid);
            end
        end
        fill_random(16);
        run_job(16'd1, $urandom, 1'b0, 1, 0, a, b);
    endtask

    task automatic test_random_jobs();
        int acc, pp;
        for (int j = 0; j < 3; j++) begin
            fill_random(32);
            run_job(16'd2, $urandom, 1'b1, 1, 0, acc, pp);
        end
    endtask

`ifdef PA_DST_REQUANT_EN
    task automatic test_requant();
        int a, b;
        fill_random(16);
        shift_val = 5'd4;
        gen_off[0] = 32'd0; gen_dat[0] = 32'h0000_0FFF;
        gen_off[1] = 32'd1; gen_dat[1] = 32'hFFFF_F000;
        gen_off[2] = 32'd5; gen_dat[2] = 32'd40;
        run_job(16'd1, 32'h2000, 1'b0, 0, 0, a, b);
        checks++;
        if (obs_data.size() < 3) begin
            errors++; $display("FAIL requant_count: got %0d expected 16", obs_data.size());
        end else begin
            checks++;
            if (obs_data[0] !== 32'h7F || obs_data[1] !== 32'hFFFF_FF80 || obs_data[2] !== 32'd3) begin
                errors++;
                $display("FAIL requant_values: got %h %h %h expected 0000007f ffffff80 00000003", obs_data[0], obs_data[1], obs_data[2]);
            end
            checks++;
            if (obs_addr[2] !== 32'h2005 || obs_strb[2] !== 4'b0010) begin
                errors++; $display("FAIL requant_addr_strb: got %h/%b expected 00002005/0010", obs_addr[2], obs_strb[2]);
            end
        end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_tile();
        test_mem_stall();
        test_push_pop();
        test_multi_tile();
        test_reset_mid();
        test_random_jobs();
`ifdef PA_DST_REQUANT_EN
        test_requant();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
